// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: FIFO read-side controller. It tracks read latency, captures returned words into a skid buffer, and drives a valid/pause stream.
// Defining FIFO_POP_ERR_CNT_EN adds the err_count (saturating) and underrun (sticky) outputs.
module fifo_pop_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  Fifo_Empty,
  input  logic                  Almost_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_out,
  input  logic                  Error_Fifo,
  input  logic                  Pausa_in,
  output logic                  pop,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            state,
  output logic [7:0]            rd_count
`ifdef FIFO_POP_ERR_CNT_EN
  ,
  output logic [7:0]            err_count,
  output logic                  underrun
`endif
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int CRD_W = $clog2(SKID_DEPTH + RD_LATENCY + 2);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CRD_W-1:0] CRD_ONE   = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_LIMIT = CRD_W'(SKID_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_STALL  = 2'd3
  } state_e;

  state_e                state_r;
  logic                  pop_r;
  logic [RD_LATENCY-1:0] pipe_r;
  logic [DATA_WIDTH-1:0] skid_r [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [7:0]            rd_count_r;

  logic [CRD_W-1:0]      credit_s;
  logic                  stall_s;
  logic                  capture_s;
  logic                  xfer_s;
  logic [RD_LATENCY-1:0] pipe_shift_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [DATA_WIDTH-1:0] data_nxt_s;

  function automatic logic [CRD_W-1:0] ones_count(input logic [RD_LATENCY-1:0] v);
    logic [CRD_W-1:0] n;
    n = CRD_W'(0);
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + CRD_W'(v[i]);
    end
    return n;
  endfunction

  if (RD_LATENCY > 1) begin : g_pipe_wide
    assign pipe_shift_s = {pipe_r[RD_LATENCY-2:0], pop_r};
  end else begin : g_pipe_one
    assign pipe_shift_s = pop_r;
  end

  // Credit, capture/transfer strobes and next pointer/count/head values.
  always_comb begin
    credit_s  = CRD_W'(cnt_r) + ones_count(pipe_r);
    stall_s   = ((credit_s + CRD_ONE) > CRD_LIMIT);
    capture_s = pipe_r[RD_LATENCY-1];
    xfer_s    = valid_r & ~Pausa_in;
    if (xfer_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({capture_s, xfer_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
    // A word landing in an otherwise empty buffer becomes the head directly.
    if (capture_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      data_nxt_s = Fifo_Data_out;
    end else begin
      data_nxt_s = skid_r[rd_ptr_nxt_s];
    end
  end

  // State and pop: pause beats credit, credit beats empty; pop is held off one cycle on the last word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
      pop_r   <= 1'b0;
    end else if (Pausa_in) begin
      state_r <= ST_PAUSED;
      pop_r   <= 1'b0;
    end else if (stall_s) begin
      state_r <= ST_STALL;
      pop_r   <= 1'b0;
    end else if (Fifo_Empty) begin
      state_r <= ST_IDLE;
      pop_r   <= 1'b0;
    end else begin
      state_r <= ST_READ;
      pop_r   <= ~(Almost_Empty & pop_r);
    end
  end

  // Read-latency pipe, skid buffer, registered head and delivered-word counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pipe_r     <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      cnt_r      <= '0;
      valid_r    <= 1'b0;
      data_r     <= '0;
      rd_count_r <= 8'd0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_r[i] <= '0;
      end
    end else begin
      pipe_r   <= pipe_shift_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      valid_r  <= (cnt_nxt_s != CNT_ZERO);
      data_r   <= data_nxt_s;
      if (capture_s) begin
        skid_r[wr_ptr_r] <= Fifo_Data_out;
        wr_ptr_r         <= wr_ptr_r + PTR_ONE;
      end
      if (xfer_s) begin
        rd_count_r <= rd_count_r + 8'd1;
      end
    end
  end

  assign pop       = pop_r;
  assign valid_out = valid_r;
  assign data_out  = data_r;
  assign state     = state_r;
  assign rd_count  = rd_count_r;

`ifdef FIFO_POP_ERR_CNT_EN
  logic [7:0] err_count_r;
  logic       underrun_r;

  // Saturating error-strobe counter and sticky pop-while-empty flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_count_r <= 8'd0;
      underrun_r  <= 1'b0;
    end else begin
      if (Error_Fifo && (err_count_r != 8'd255)) begin
        err_count_r <= err_count_r + 8'd1;
      end
      if (pop_r && Fifo_Empty) begin
        underrun_r <= 1'b1;
      end
    end
  end

  assign err_count = err_count_r;
  assign underrun  = underrun_r;
`else
  logic unused_error_fifo_s;
  assign unused_error_fifo_s = Error_Fifo;
`endif

endmodule
